// File: rtl/rename_map_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rename_map_stage_pkg : shared rename/issue sizes and issueinfo field offsets
// Revision: 1.0
// ----------------------------------------------------------------------------
package rename_map_stage_pkg;

  localparam int NUM_ARCH    = 32;
  localparam int NUM_PHYS    = 64;
  localparam int TAG_W       = 6;
  localparam int ARCH_W      = 5;
  localparam int PAYLOAD_W   = 168;

  localparam int MAPA_LSB    = 0;
  localparam int MAPB_LSB    = 6;
  localparam int MAPWR_LSB   = 12;
  localparam int PAYLOAD_LSB = 18;
  localparam int ISSUEINFO_W = 186;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [ARCH_W-1:0] arch_t;

endpackage
`default_nettype wire

// File: rtl/rename_map_stage_free_list_alloc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// free_list_alloc : physical tag free bitmap with lowest-index allocation
// Revision: 1.0
// ----------------------------------------------------------------------------
module free_list_alloc
  import rename_map_stage_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                alloc_en,
  output tag_t                alloc_tag,
  output logic                none_free,
  input  logic                free_en,
  input  tag_t                free_tag,
  input  logic                rebuild_en,
  input  logic [NUM_PHYS-1:0] rebuild_vec
);

  localparam logic [NUM_PHYS-1:0] RESET_FREE =
    {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
  localparam logic [NUM_PHYS-1:0] TAG0_MASK =
    {{(NUM_PHYS-1){1'b1}}, 1'b0};

  logic [NUM_PHYS-1:0] free_q;

  // Scan downward so the last hit is the lowest set index.
  always_comb begin
    alloc_tag = '0;
    for (int p = NUM_PHYS-1; p >= 0; p--) begin
      if (free_q[p]) alloc_tag = tag_t'(p);
    end
  end

  assign none_free = ~|free_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      free_q <= RESET_FREE;
    end else if (rebuild_en) begin
      free_q <= rebuild_vec & TAG0_MASK;
    end else begin
      if (alloc_en && !none_free) free_q[alloc_tag] <= 1'b0;
      if (free_en && free_tag != '0) free_q[free_tag] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rename_map_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rename_map_stage : RAT/RRAT rename, tag allocation, ready vector, sequencing
// Revision: 1.0
// ----------------------------------------------------------------------------
module rename_map_stage
  import rename_map_stage_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   STALL,
  input  logic                   FLUSH,
  input  logic                   dec_valid,
  input  logic [ARCH_W-1:0]      dec_rs,
  input  logic [ARCH_W-1:0]      dec_rt,
  input  logic [ARCH_W-1:0]      dec_wr,
  input  logic                   dec_wr_en,
  input  logic [PAYLOAD_W-1:0]   dec_payload,
  output logic                   dec_ready,
  output logic                   rename_enque,
  output logic [31:0]            rename_instr_num,
  output logic [ISSUEINFO_W-1:0] rename_issueinfo,
  output logic [TAG_W-1:0]       rename_old_map,
  output logic [NUM_PHYS-1:0]    busy,
  input  logic                   exe_broadcast,
  input  logic [TAG_W-1:0]       exe_broadcast_map,
  input  logic                   commit_valid,
  input  logic [ARCH_W-1:0]      commit_arch,
  input  logic [TAG_W-1:0]       commit_new_map,
  input  logic [TAG_W-1:0]       commit_old_map
);

  tag_t                   rat  [NUM_ARCH];
  tag_t                   rrat [NUM_ARCH];
  logic [NUM_PHYS-1:0]    busy_q;
  logic [NUM_PHYS-1:0]    bcast_vec;
  logic [NUM_PHYS-1:0]    rrat_live;
  logic [31:0]            seq;
  logic                   need_tag;
  logic                   none_free;
  logic                   accept;
  logic                   alloc_en;
  logic                   commit_en;
  tag_t                   alloc_tag;
  tag_t                   map_a;
  tag_t                   map_b;
  tag_t                   map_wr;
  tag_t                   old_map;
  logic [ISSUEINFO_W-1:0] issueinfo_next;

  assign need_tag  = dec_wr_en && (dec_wr != '0);
  assign dec_ready = !STALL && !FLUSH && (!need_tag || !none_free);
  assign accept    = dec_valid && dec_ready;
  assign alloc_en  = accept && need_tag;
  assign commit_en = commit_valid && !FLUSH;

  // Sources see the RAT before this instruction's own destination update.
  assign map_a   = (dec_rs == '0) ? '0 : rat[dec_rs];
  assign map_b   = (dec_rt == '0) ? '0 : rat[dec_rt];
  assign map_wr  = need_tag ? alloc_tag : '0;
  assign old_map = need_tag ? rat[dec_wr] : '0;

  always_comb begin
    issueinfo_next = '0;
    issueinfo_next[MAPA_LSB +: TAG_W]        = map_a;
    issueinfo_next[MAPB_LSB +: TAG_W]        = map_b;
    issueinfo_next[MAPWR_LSB +: TAG_W]       = map_wr;
    issueinfo_next[PAYLOAD_LSB +: PAYLOAD_W] = dec_payload;
  end

  always_comb begin
    rrat_live = '0;
    for (int i = 0; i < NUM_ARCH; i++) begin
      rrat_live[rrat[i]] = 1'b1;
    end
  end

  always_comb begin
    bcast_vec = '0;
    if (exe_broadcast && exe_broadcast_map != '0) bcast_vec[exe_broadcast_map] = 1'b1;
  end

  // Same-cycle wakeup is visible to issue before it lands in busy_q.
  assign busy = busy_q | bcast_vec;

  free_list_alloc u_free_list (
    .CLK         (CLK),
    .RESET       (RESET),
    .alloc_en    (alloc_en),
    .alloc_tag   (alloc_tag),
    .none_free   (none_free),
    .free_en     (commit_en),
    .free_tag    (commit_old_map),
    .rebuild_en  (FLUSH),
    .rebuild_vec (~rrat_live)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat[i]  <= tag_t'(i);
        rrat[i] <= tag_t'(i);
      end
    end else if (FLUSH) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat[i] <= rrat[i];
      end
    end else begin
      if (alloc_en) rat[dec_wr] <= alloc_tag;
      if (commit_valid && commit_arch != '0) rrat[commit_arch] <= commit_new_map;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy_q <= '1;
    end else if (FLUSH) begin
      busy_q <= '1;
    end else begin
      busy_q <= busy_q | bcast_vec;
      if (alloc_en) busy_q[alloc_tag] <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rename_enque     <= 1'b0;
      rename_instr_num <= '0;
      rename_issueinfo <= '0;
      rename_old_map   <= '0;
      seq              <= 32'd1;
    end else if (FLUSH) begin
      rename_enque     <= 1'b0;
      rename_instr_num <= '0;
      rename_issueinfo <= '0;
      rename_old_map   <= '0;
    end else if (!STALL) begin
      if (accept) begin
        rename_enque     <= 1'b1;
        rename_instr_num <= seq;
        rename_issueinfo <= issueinfo_next;
        rename_old_map   <= old_map;
        seq              <= seq + 32'd1;
      end else begin
        rename_enque     <= 1'b0;
        rename_instr_num <= '0;
        rename_issueinfo <= '0;
        rename_old_map   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_map_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rename_map_stage : scoreboard bench for the rename/map stage
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_rename_map_stage;
  import rename_map_stage_pkg::*;

  logic                   CLK = 1'b0;
  logic                   RESET;
  logic                   STALL;
  logic                   FLUSH;
  logic                   dec_valid;
  logic [ARCH_W-1:0]      dec_rs;
  logic [ARCH_W-1:0]      dec_rt;
  logic [ARCH_W-1:0]      dec_wr;
  logic                   dec_wr_en;
  logic [PAYLOAD_W-1:0]   dec_payload;
  logic                   dec_ready;
  logic                   rename_enque;
  logic [31:0]            rename_instr_num;
  logic [ISSUEINFO_W-1:0] rename_issueinfo;
  logic [TAG_W-1:0]       rename_old_map;
  logic [NUM_PHYS-1:0]    busy;
  logic                   exe_broadcast;
  logic [TAG_W-1:0]       exe_broadcast_map;
  logic                   commit_valid;
  logic [ARCH_W-1:0]      commit_arch;
  logic [TAG_W-1:0]       commit_new_map;
  logic [TAG_W-1:0]       commit_old_map;

  rename_map_stage dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .FLUSH             (FLUSH),
    .dec_valid         (dec_valid),
    .dec_rs            (dec_rs),
    .dec_rt            (dec_rt),
    .dec_wr            (dec_wr),
    .dec_wr_en         (dec_wr_en),
    .dec_payload       (dec_payload),
    .dec_ready         (dec_ready),
    .rename_enque      (rename_enque),
    .rename_instr_num  (rename_instr_num),
    .rename_issueinfo  (rename_issueinfo),
    .rename_old_map    (rename_old_map),
    .busy              (busy),
    .exe_broadcast     (exe_broadcast),
    .exe_broadcast_map (exe_broadcast_map),
    .commit_valid      (commit_valid),
    .commit_arch       (commit_arch),
    .commit_new_map    (commit_new_map),
    .commit_old_map    (commit_old_map)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [ISSUEINFO_W-1:0] info;
    logic [31:0]            num;
    logic [TAG_W-1:0]       old;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  exp_t mon_e;
  logic mon_live;
  int   total = 0;
  int   bad   = 0;

  logic [TAG_W-1:0]    m_rat  [NUM_ARCH];
  logic [TAG_W-1:0]    m_rrat [NUM_ARCH];
  logic [NUM_PHYS-1:0] m_free;
  logic [31:0]         m_seq;

  // Scoreboard: every edge that is not stalled/flushed/reset updates outputs.
  always @(posedge CLK) begin
    mon_live = RESET && !STALL && !FLUSH;
    #1;
    if (mon_live) begin
      total++;
      if (rename_enque) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_enque: got num=%0d info=%h, required no enqueue", rename_instr_num, rename_issueinfo);
        end else begin
          mon_e = sb.pop_front();
          if ({rename_issueinfo, rename_instr_num, rename_old_map} !== mon_e) begin
            bad++;
            $display("FAIL sb_enque: got info=%h num=%0d old=%0d, required info=%h num=%0d old=%0d",
                     rename_issueinfo, rename_instr_num, rename_old_map, mon_e.info, mon_e.num, mon_e.old);
          end
        end
      end else if (rename_issueinfo !== '0 || rename_instr_num !== '0 || rename_old_map !== '0) begin
        bad++;
        $display("FAIL sb_idle_zero: got info=%h num=%0d old=%0d, required all zero",
                 rename_issueinfo, rename_instr_num, rename_old_map);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    STALL = 1'b0; FLUSH = 1'b0; dec_valid = 1'b0; dec_rs = '0; dec_rt = '0;
    dec_wr = '0; dec_wr_en = 1'b0; dec_payload = '0; exe_broadcast = 1'b0;
    exe_broadcast_map = '0; commit_valid = 1'b0; commit_arch = '0;
    commit_new_map = '0; commit_old_map = '0;
  endtask

  task automatic set_dec(input logic v, input int rs, input int rt, input int wr, input logic wen);
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    dec_valid = v; dec_rs = ARCH_W'(rs); dec_rt = ARCH_W'(rt);
    dec_wr = ARCH_W'(wr); dec_wr_en = wen; dec_payload = r[PAYLOAD_W-1:0];
  endtask

  task automatic model_init();
    for (int i = 0; i < NUM_ARCH; i++) begin
      m_rat[i]  = TAG_W'(i);
      m_rrat[i] = TAG_W'(i);
    end
    m_free = {32'hFFFF_FFFF, 32'h0};
    m_seq  = 32'd1;
    sb.delete();
  endtask

  // Expected result of accepting whatever is currently on the decode inputs.
  task automatic model_accept();
    exp_t e;
    logic [TAG_W-1:0] a, b, w, old;
    a = (dec_rs == 0) ? '0 : m_rat[dec_rs];
    b = (dec_rt == 0) ? '0 : m_rat[dec_rt];
    w = '0; old = '0;
    if (dec_wr_en && dec_wr != 0) begin
      for (int p = NUM_PHYS-1; p >= 1; p--) if (m_free[p]) w = TAG_W'(p);
      old = m_rat[dec_wr];
      m_rat[dec_wr] = w;
      m_free[w] = 1'b0;
    end
    e.info = {dec_payload, w, b, a};
    e.num  = m_seq;
    e.old  = old;
    m_seq  = m_seq + 32'd1;
    sb.push_back(e);
    last_exp = e;
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
    model_init();
  endtask

  task automatic test_reset();
    idle();
    RESET = 1'b0;
    tick();
    total++;
    if ({rename_enque, rename_instr_num, rename_issueinfo, rename_old_map} !== '0 || dec_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_outputs: got enque=%b num=%0d old=%0d ready=%b, required zeros and ready=1",
               rename_enque, rename_instr_num, rename_old_map, dec_ready);
    end
    total++;
    if (busy !== {NUM_PHYS{1'b1}}) begin
      bad++; $display("FAIL reset_busy: got %h, required all ones", busy);
    end
    RESET = 1'b1;
    model_init();
    set_dec(1'b1, 0, 0, 1, 1'b1);
    model_accept();
    tick();
    idle();
    RESET = 1'b0;
    #1;
    total++;
    if (rename_enque !== 1'b0 || rename_instr_num !== 32'd0 || busy !== {NUM_PHYS{1'b1}}) begin
      bad++;
      $display("FAIL reset_async: got enque=%b num=%0d busy=%h, required 0, 0, all ones", rename_enque, rename_instr_num, busy);
    end
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    set_dec(1'b1, 5, 0, 5, 1'b1);
    #1;
    total++;
    if (dec_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b, required 1", dec_ready); end
    model_accept();
    tick();
    idle();
    #1;
    total++;
    if ({rename_enque, rename_issueinfo[17:0], rename_old_map, rename_instr_num} !== {1'b1, 6'd32, 6'd0, 6'd5, 6'd5, 32'd1}) begin
      bad++;
      $display("FAIL basic_fields: got enque=%b maps=%h old=%0d num=%0d, required 1 wr=32 b=0 a=5 old=5 num=1",
               rename_enque, rename_issueinfo[17:0], rename_old_map, rename_instr_num);
    end
    total++;
    if (busy[32] !== 1'b0) begin bad++; $display("FAIL basic_busy32: got %b, required 0", busy[32]); end
    set_dec(1'b1, 5, 6, 6, 1'b1);
    model_accept();
    tick();
    idle();
    total++;
    if ({rename_issueinfo[17:0], rename_old_map, rename_instr_num} !== {6'd33, 6'd6, 6'd32, 6'd6, 32'd2}) begin
      bad++;
      $display("FAIL basic_dep: got maps=%h old=%0d num=%0d, required wr=33 b=6 a=32 old=6 num=2",
               rename_issueinfo[17:0], rename_old_map, rename_instr_num);
    end
    tick();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL basic_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_exhaust();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      set_dec(1'b1, 1, 2, 1, 1'b1);
      #1;
      total++;
      if (dec_ready !== 1'b1) begin bad++; $display("FAIL exhaust_ready[%0d]: got %b, required 1", i, dec_ready); end
      model_accept();
      tick();
      total++;
      if (rename_issueinfo[17:12] !== 6'(32 + i)) begin
        bad++; $display("FAIL exhaust_tag[%0d]: got %0d, required %0d", i, rename_issueinfo[17:12], 32 + i);
      end
    end
    set_dec(1'b1, 1, 2, 1, 1'b1);
    #1;
    total++;
    if (dec_ready !== 1'b0) begin bad++; $display("FAIL exhaust_full: got ready=%b, required 0", dec_ready); end
    tick();
    total++;
    if (rename_enque !== 1'b0) begin bad++; $display("FAIL exhaust_no_enq: got %b, required 0", rename_enque); end
  endtask

  task automatic test_wr0_when_empty();
    set_dec(1'b1, 1, 0, 0, 1'b1);
    #1;
    total++;
    if (dec_ready !== 1'b1) begin bad++; $display("FAIL wr0_ready: got %b, required 1", dec_ready); end
    model_accept();
    tick();
    total++;
    if (rename_issueinfo[17:12] !== 6'd0 || rename_old_map !== 6'd0 || rename_issueinfo[5:0] !== 6'd63) begin
      bad++;
      $display("FAIL wr0_fields: got wr=%0d old=%0d a=%0d, required 0 0 63",
               rename_issueinfo[17:12], rename_old_map, rename_issueinfo[5:0]);
    end
    set_dec(1'b1, 0, 0, 2, 1'b1);
    #1;
    total++;
    if (dec_ready !== 1'b0) begin bad++; $display("FAIL wr0_still_full: got %b, required 0", dec_ready); end
    tick();
  endtask

  task automatic test_commit_free();
    set_dec(1'b1, 0, 0, 2, 1'b1);
    commit_valid = 1'b1; commit_arch = 5'd1; commit_new_map = 6'd32; commit_old_map = 6'd1;
    #1;
    total++;
    if (dec_ready !== 1'b0) begin bad++; $display("FAIL commit_same_cycle: got ready=%b, required 0", dec_ready); end
    tick();
    m_rrat[1] = 6'd32;
    m_free[1] = 1'b1;
    commit_valid = 1'b0;
    #1;
    total++;
    if (dec_ready !== 1'b1) begin bad++; $display("FAIL commit_next_ready: got %b, required 1", dec_ready); end
    model_accept();
    tick();
    idle();
    total++;
    if (rename_issueinfo[17:12] !== 6'd1 || rename_old_map !== 6'd2) begin
      bad++;
      $display("FAIL commit_realloc: got wr=%0d old=%0d, required 1 2", rename_issueinfo[17:12], rename_old_map);
    end
    tick();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL commit_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_broadcast();
    do_reset();
    set_dec(1'b1, 0, 0, 5, 1'b1);
    model_accept();
    tick();
    idle();
    exe_broadcast = 1'b1; exe_broadcast_map = 6'd32;
    #1;
    total++;
    if (busy[32] !== 1'b1) begin bad++; $display("FAIL bcast_same_cycle: got %b, required 1", busy[32]); end
    tick();
    exe_broadcast = 1'b0;
    #1;
    total++;
    if (busy !== {NUM_PHYS{1'b1}}) begin bad++; $display("FAIL bcast_registered: got %h, required all ones", busy); end
    set_dec(1'b1, 0, 0, 6, 1'b1);
    exe_broadcast = 1'b1; exe_broadcast_map = 6'd33;
    model_accept();
    tick();
    idle();
    #1;
    total++;
    if (busy[33] !== 1'b0) begin bad++; $display("FAIL bcast_alloc_override: got %b, required 0", busy[33]); end
    tick();
  endtask

  task automatic test_stall();
    exp_t held;
    do_reset();
    set_dec(1'b1, 0, 0, 7, 1'b1);
    model_accept();
    held = last_exp;
    tick();
    STALL = 1'b1;
    set_dec(1'b1, 7, 0, 8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (dec_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b, required 0", k, dec_ready); end
      tick();
      total++;
      if ({rename_enque, rename_issueinfo, rename_instr_num, rename_old_map} !== {1'b1, held}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got enque=%b num=%0d old=%0d, required 1 %0d %0d",
                 k, rename_enque, rename_instr_num, rename_old_map, held.num, held.old);
      end
    end
    STALL = 1'b0;
    #1;
    total++;
    if (dec_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b, required 1", dec_ready); end
    model_accept();
    tick();
    idle();
    total++;
    if (rename_issueinfo[17:12] !== 6'd33 || rename_instr_num !== 32'd2 || rename_issueinfo[5:0] !== 6'd32) begin
      bad++;
      $display("FAIL stall_release: got wr=%0d num=%0d a=%0d, required 33 2 32",
               rename_issueinfo[17:12], rename_instr_num, rename_issueinfo[5:0]);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_dec(1'b1, 0, 0, 3, 1'b1);
    model_accept();
    tick();
    set_dec(1'b1, 0, 0, 3, 1'b1);
    model_accept();
    tick();
    idle();
    commit_valid = 1'b1; commit_arch = 5'd3; commit_new_map = 6'd32; commit_old_map = 6'd3;
    tick();
    m_rrat[3] = 6'd32;
    m_free[3] = 1'b1;
    commit_valid = 1'b0;
    FLUSH = 1'b1;
    set_dec(1'b1, 0, 0, 9, 1'b1);
    #1;
    total++;
    if (dec_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b, required 0", dec_ready); end
    tick();
    m_free = '1;
    m_free[0] = 1'b0;
    for (int i = 0; i < NUM_ARCH; i++) begin
      m_rat[i] = m_rrat[i];
      m_free[m_rrat[i]] = 1'b0;
    end
    idle();
    #1;
    total++;
    if ({rename_enque, rename_instr_num, rename_issueinfo, rename_old_map} !== '0) begin
      bad++; $display("FAIL flush_clear: got enque=%b num=%0d, required 0 0", rename_enque, rename_instr_num);
    end
    total++;
    if (busy !== {NUM_PHYS{1'b1}}) begin bad++; $display("FAIL flush_busy: got %h, required all ones", busy); end
    set_dec(1'b1, 3, 0, 4, 1'b1);
    model_accept();
    tick();
    total++;
    if ({rename_issueinfo[17:12], rename_issueinfo[5:0], rename_old_map, rename_instr_num} !== {6'd3, 6'd32, 6'd4, 32'd3}) begin
      bad++;
      $display("FAIL flush_after: got wr=%0d a=%0d old=%0d num=%0d, required 3 32 4 3",
               rename_issueinfo[17:12], rename_issueinfo[5:0], rename_old_map, rename_instr_num);
    end
    set_dec(1'b1, 0, 0, 5, 1'b1);
    model_accept();
    tick();
    idle();
    total++;
    if (rename_issueinfo[17:12] !== 6'd33 || rename_instr_num !== 32'd4) begin
      bad++;
      $display("FAIL flush_free33: got wr=%0d num=%0d, required 33 4", rename_issueinfo[17:12], rename_instr_num);
    end
    tick();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL flush_drain: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    idle();
    RESET = 1'b0;
    model_init();
    test_reset();
    test_basic();
    test_exhaust();
    test_wr0_when_empty();
    test_commit_free();
    test_broadcast();
    test_stall();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
